// File: rtl/ro_freq_meter_pkg.sv
// Shared definitions for the ring-oscillator frequency meter.
//   state_t    : measurement FSM states
//   SETTLE_DEF : default settle length in clk cycles
//   RO_N_DEF   : default oscillator stage-buffer width
package ro_freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int SETTLE_DEF = 8;
  localparam int RO_N_DEF   = 19;

endpackage

// File: rtl/ro_freq_meter_edge.sv
// Brings the free-running oscillator output into the clk domain and flags
// its rising edges. ro_out is only ever sampled, never used as a clock.
//   i_clk   : system clock
//   i_rst_n : synchronous active-low reset
//   i_async : oscillator output, asynchronous to i_clk
//   o_rise  : one-cycle pulse per synchronised rising edge
module ro_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_s1, r_s2, r_s3;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // r_s3 is the previous synchronised level, so this is the 0->1 step.
  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/ro_freq_meter.sv
// Gated ring-oscillator frequency meter. Each accepted start enables the
// oscillator, lets it settle, counts its rising edges over a programmable
// window and XOR-folds every stage-buffer snapshot taken in that window.
// Results are held until the next completed measurement.
//   i_clk, i_rst_n  : clock, synchronous active-low reset
//   i_start         : begin a measurement (IDLE only)
//   i_abort         : cancel a running measurement
//   i_window        : MEASURE length in clk cycles, latched at start
//   i_ro_out        : oscillator output (async)
//   i_ro_buffer     : registered oscillator stage snapshot
//   o_ro_activate   : oscillator enable
//   o_busy          : measurement in progress
//   o_done          : one-cycle pulse when results update
//   o_edge_count    : edges counted in the last completed window
//   o_saturated     : edge counter reached all-ones in that window
//   o_xor_fold      : XOR of all buffer samples in that window
module ro_freq_meter
  import ro_freq_meter_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16,
  parameter int SETTLE = SETTLE_DEF,
  parameter int RO_N   = RO_N_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIN_W-1:0] i_window,
  input  logic             i_ro_out,
  input  logic [RO_N-1:0]  i_ro_buffer,
  output logic             o_ro_activate,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_edge_count,
  output logic             o_saturated,
  output logic [RO_N-1:0]  o_xor_fold
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state, w_next;
  logic [SW-1:0]    r_set;
  logic [WIN_W-1:0] r_win;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic [RO_N-1:0]  r_fold;
  logic             r_run;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt_q;
  logic             r_sat_q;
  logic [RO_N-1:0]  r_fold_q;
  logic             w_rise;

  ro_edge_sync u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_ro_out),
    .o_rise  (w_rise)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (i_start) w_next = ST_SETTLE;
      ST_SETTLE:  if (i_abort) w_next = ST_IDLE;
                  else if (r_set == SW'(SETTLE - 1))
                    w_next = (r_win == '0) ? ST_DONE : ST_MEASURE;
      // Abort wins over the final MEASURE cycle.
      ST_MEASURE: if (i_abort) w_next = ST_IDLE;
                  else if (r_win == WIN_W'(1)) w_next = ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_set    <= '0;
      r_win    <= '0;
      r_cnt    <= '0;
      r_sat    <= 1'b0;
      r_fold   <= '0;
      r_run    <= 1'b0;
      r_done   <= 1'b0;
      r_cnt_q  <= '0;
      r_sat_q  <= 1'b0;
      r_fold_q <= '0;
    end else begin
      r_state <= w_next;
      // Enable follows the next state so it tracks SETTLE/MEASURE exactly.
      r_run   <= (w_next == ST_SETTLE) || (w_next == ST_MEASURE);
      r_done  <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: if (i_start) begin
          r_win  <= i_window;
          r_set  <= '0;
          r_cnt  <= '0;
          r_sat  <= 1'b0;
          r_fold <= '0;
        end
        ST_SETTLE: r_set <= r_set + 1'b1;
        ST_MEASURE: begin
          r_win  <= r_win - 1'b1;
          r_fold <= r_fold ^ i_ro_buffer;
          if (w_rise) begin
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
            // Flag as soon as the count reaches all-ones.
            if (r_cnt >= CNT_MAX - 1'b1) r_sat <= 1'b1;
          end
        end
        ST_DONE: begin
          r_cnt_q  <= r_cnt;
          r_sat_q  <= r_sat;
          r_fold_q <= r_fold;
        end
        default: ;
      endcase
    end
  end

  assign o_ro_activate = r_run;
  assign o_busy        = r_run;
  assign o_done        = r_done;
  assign o_edge_count  = r_cnt_q;
  assign o_saturated   = r_sat_q;
  assign o_xor_fold    = r_fold_q;

endmodule
